// File: rtl/ufloat_add_pipe.sv
// Unsigned mini-float adder ({exp, mant}, hidden 1 always set) run as a 5-state machine.
// Define UFADD_ROUND_EN for round-half-up of the result; leave it undefined to truncate.
module ufloat_add_pipe #(
  parameter int EW = 3,
  parameter int MW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW+MW-1:0] a,
  input  logic [EW+MW-1:0] b,
  output logic [EW+MW-1:0] c,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

`ifdef UFADD_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
  state_t state, next_state;

  logic [EW+MW-1:0] a_q, b_q;
  logic [EW-1:0]    e_l;
  logic [MW-1:0]    m_l;
  logic [MW+1:0]    aligned;
  logic [MW+2:0]    sum_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ALIGN;
      end
      ALIGN: next_state = ADD;
      ADD:   next_state = NORM;
      NORM:  next_state = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Alignment: ties go to a, so equal exponents give the same sum in either order.
  logic [EW-1:0] ea, eb, e_big, diff;
  logic [MW-1:0] ma, mb, m_big, m_small;
  logic [MW+1:0] small_ext, aligned_d;

  always_comb begin
    ea = a_q[EW+MW-1:MW];
    eb = b_q[EW+MW-1:MW];
    ma = a_q[MW-1:0];
    mb = b_q[MW-1:0];
    if (ea >= eb) begin
      e_big   = ea;
      m_big   = ma;
      m_small = mb;
      diff    = ea - eb;
    end else begin
      e_big   = eb;
      m_big   = mb;
      m_small = ma;
      diff    = eb - ea;
    end
    small_ext = {1'b1, m_small, 1'b0};
    if (32'(diff) > 32'(MW + 1)) aligned_d = '0;
    else                         aligned_d = small_ext >> diff;
  end

  logic [MW+2:0] sum_d;
  assign sum_d = {1'b0, 1'b1, m_l, 1'b0} + {1'b0, aligned};

  // Normalise a carry-out, optionally round, then saturate when the exponent overflows.
  logic             carry, rnd, round_inc, ovf_d;
  logic [MW-1:0]    mant_n;
  logic [MW:0]      mant_r;
  logic [EW:0]      exp_f;
  logic [EW+MW-1:0] c_d;

  always_comb begin
    carry     = sum_q[MW+2];
    mant_n    = carry ? sum_q[MW+1:2] : sum_q[MW:1];
    rnd       = carry ? sum_q[1] : sum_q[0];
    round_inc = rnd & ROUND_EN;
    mant_r    = {1'b0, mant_n} + {{MW{1'b0}}, round_inc};
    exp_f     = {1'b0, e_l} + {{EW{1'b0}}, carry} + {{EW{1'b0}}, mant_r[MW]};
    ovf_d     = exp_f[EW];
    c_d       = ovf_d ? '1 : {exp_f[EW-1:0], mant_r[MW-1:0]};
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (in_valid) begin
          a_q <= a;
          b_q <= b;
        end
      end
      ALIGN: begin
        e_l     <= e_big;
        m_l     <= m_big;
        aligned <= aligned_d;
      end
      ADD:     sum_q <= sum_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c   <= '0;
      ovf <= 1'b0;
    end else if (state == NORM) begin
      c   <= c_d;
      ovf <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ufloat_add_pipe.sv
// Scoreboard bench for ufloat_add_pipe (EW=3, MW=4); expected {ovf,c} values are queued at accept.
// Follows UFADD_ROUND_EN the same way the design does.
module tb_ufloat_add_pipe;

  localparam int EW = 3;
  localparam int MW = 4;
  localparam int W  = EW + MW;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b, c;
  logic         ovf;
  logic         out_valid;
  logic         out_ready;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];

  ufloat_add_pipe #(.EW(EW), .MW(MW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference: work in guard-bit units of the larger operand and floor away what falls below them.
  function automatic logic [7:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
    int ea, eb, el, es, ml, ms, e, mant, rnd;
    longint s_units, aligned_v, sum;
    ea = int'(av[W-1:MW]); eb = int'(bv[W-1:MW]);
    if (ea >= eb) begin el = ea; ml = int'(av[MW-1:0]); es = eb; ms = int'(bv[MW-1:0]); end
    else          begin el = eb; ml = int'(bv[MW-1:0]); es = ea; ms = int'(av[MW-1:0]); end
    s_units   = longint'((2**MW + ms) * 2) * (longint'(1) << es);
    aligned_v = s_units / (longint'(1) << el);
    sum = longint'((2**MW + ml) * 2) + aligned_v;
    e = el;
    if (sum >= 2**(MW+2)) begin
      sum = sum / 2;
      e++;
    end
    rnd  = int'(sum % 2);
    mant = int'(sum / 2) - 2**MW;
`ifdef UFADD_ROUND_EN
    mant = mant + rnd;
    if (mant == 2**MW) begin
      mant = 0;
      e++;
    end
`else
    rnd = 0;
`endif
    if (e > 2**EW - 1) return 8'hFF;
    return {1'b0, 3'(e), 4'(mant)};
  endfunction

  // Called #1 after an edge with the DUT idle; leaves the DUT idle again, #1 after an edge.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [7:0] expv);
    int lat;
    checkOutput("in_ready_idle", 32'(in_ready), 1);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(expv);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("edges_incl_accept", 32'(lat), 4);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) checkOutput("spurious_out", 32'(out_valid), 0);
      else checkOutput("result", 32'({ovf, c}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int ghost, waitc;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rst_in_ready", 32'(in_ready), 1);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_c", 32'(c), 0);
    checkOutput("rst_ovf", 32'(ovf), 0);

    applyStimulus(7'b101_1000, 7'b100_1000, 8'b0_110_0010);
    applyStimulus(7'b100_1000, 7'b101_1000, 8'b0_110_0010);
    applyStimulus(7'b110_0011, 7'b100_1000, 8'b0_110_1001);
`ifdef UFADD_ROUND_EN
    applyStimulus(7'b010_0000, 7'b001_0001, 8'b0_010_1001);
    applyStimulus(7'b011_1111, 7'b010_0000, 8'b0_100_0100);
`else
    applyStimulus(7'b010_0000, 7'b001_0001, 8'b0_010_1000);
    applyStimulus(7'b011_1111, 7'b010_0000, 8'b0_100_0011);
`endif
    applyStimulus(7'b111_1111, 7'b111_0000, 8'b1_111_1111);
    applyStimulus(7'b000_0000, 7'b000_0000, 8'b0_001_0000);
    applyStimulus(7'b111_0000, 7'b000_1111, 8'b0_111_0000);
    applyStimulus(7'b011_0101, 7'b011_0101, 8'b0_100_0101);

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      applyStimulus(ra, rb, model(ra, rb));
    end

    // Consumer stall: result must hold and new operands must be ignored.
    out_ready = 1'b0;
    a = 7'b110_0011; b = 7'b100_1000; in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(8'b0_110_1001);
    #1 in_valid = 1'b0;
    waitc = 0;
    while (!out_valid && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    checkOutput("stall_reached_done", 32'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      checkOutput("stall_result", 32'({ovf, c}), 32'(8'b0_110_1001));
      checkOutput("stall_out_valid", 32'(out_valid), 1);
      checkOutput("stall_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_in_ready", 32'(in_ready), 1);
    checkOutput("release_out_valid", 32'(out_valid), 0);

    // Reset while in ADD: operation is dropped, nothing queued for it.
    a = 7'b101_1000; b = 7'b100_1000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midrst_in_ready", 32'(in_ready), 1);
    checkOutput("midrst_out_valid", 32'(out_valid), 0);
    checkOutput("midrst_result", 32'({ovf, c}), 0);
    ghost = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) ghost++;
    end
    checkOutput("midrst_no_result", 32'(ghost), 0);
    applyStimulus(7'b010_0000, 7'b010_0000, 8'b0_011_0000);

    repeat (2) @(posedge clk);
    #1 checkOutput("sb_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
